// File: rtl/alu_mc_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the multi-cycle ALU.
package alu_mc_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_DIV = 4'd14;

  localparam int FLAG_V = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/alu_mc_if.sv
// Execute-stage request/response bundle for alu_mc.
interface alu_mc_if #(parameter int WIDTH = 16);
  logic             start;
  logic [3:0]       op;
  logic             en_imm;
  logic [WIDTH-1:0] rD_data;
  logic [WIDTH-1:0] rS_data;
  logic [WIDTH-1:0] immediate;
  logic [3:0]       flags_in;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic [3:0]       flags_out;
  logic             busy;
  logic             done;

  modport master (output start, op, en_imm, rD_data, rS_data, immediate, flags_in,
                  input  out, out_hi, flags_out, busy, done);
  modport slave  (input  start, op, en_imm, rD_data, rS_data, immediate, flags_in,
                  output out, out_hi, flags_out, busy, done);
endinterface

// File: rtl/alu_mc_seq.sv
// Iterative MUL (shift-add) / DIV (restoring) engine; one bit per step, WIDTH steps.
module alu_mc_seq #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int SHW = $clog2(WIDTH);

  // hi: product high half / partial remainder; lo: multiplier bits / quotient bits
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             div_q, div_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   sum, rem_sh, trial;

  // One iteration of either algorithm, or a fresh load
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_q};
    if (load) begin
      hi_d  = '0;
      lo_d  = a;
      b_d   = b;
      div_d = is_div;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        // remainder stays below b, so a successful trial fits in WIDTH bits
        if (!trial[WIDTH]) begin
          hi_d = trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign last   = step && (cnt_q == SHW'(WIDTH - 1));
  assign res_lo = lo_q;
  assign res_hi = hi_q;
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle datapath plus MUL/DIV sequencer behind start/busy/done.
module alu_mc import alu_mc_pkg::*; #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    rst,
  alu_mc_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d, hi_q, hi_d;
  logic [3:0]       op_q, op_d, flags_q, flags_d;
  logic             cin_q, cin_d, busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]   b_sel, res, res_hi, seq_lo, seq_hi;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] rot;
  logic [SHW-1:0]     sh;
  logic               is_long, accept, seq_last, c, v, z;

  assign b_sel   = bus.en_imm ? bus.immediate : bus.rS_data;
  assign is_long = (bus.op == OP_MUL) || (bus.op == OP_DIV && b_sel != '0);
  // a finishing MUL/DIV still shows busy in its DONE cycle, so no overlap there
  assign accept  = bus.start && !busy_q && (state_q != ST_RUN);
  assign sh      = b_q[SHW-1:0];

  alu_mc_seq #(.WIDTH(WIDTH)) u_seq (
    .clk(clk), .rst(rst),
    .load(accept && is_long), .is_div(bus.op == OP_DIV),
    .a(bus.rD_data), .b(b_sel),
    .step(state_q == ST_RUN), .last(seq_last),
    .res_lo(seq_lo), .res_hi(seq_hi)
  );

  // Result and flags from the captured operands (and sequencer for MUL/DIV)
  always_comb begin
    res    = '0;
    res_hi = '0;
    sum    = '0;
    rot    = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        sum = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q && op_q == OP_ADC);
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        sum = {1'b0, a_q} - {1'b0, b_q} - (WIDTH+1)'(cin_q && op_q == OP_SBB);
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      OP_MOV: res = b_q;
      OP_SHL: begin
        sum = {1'b0, a_q} << sh;
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
      end
      OP_SHR: begin
        sum = {a_q, 1'b0} >> sh;
        res = sum[WIDTH:1];
        c   = sum[0];
      end
      OP_ROL: begin
        rot = {a_q, a_q} << sh;
        res = rot[2*WIDTH-1:WIDTH];
        c   = res[0];
      end
      OP_ROR: begin
        rot = {a_q, a_q} >> sh;
        res = rot[WIDTH-1:0];
        c   = res[WIDTH-1];
      end
      OP_MUL: begin
        res    = seq_lo;
        res_hi = seq_hi;
        c      = |seq_hi;
        v      = |seq_hi;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res    = '1;
          res_hi = a_q;
          v      = 1'b1;
        end else begin
          res    = seq_lo;
          res_hi = seq_hi;
        end
      end
      default: res = '0;
    endcase
    z = (op_q == OP_MUL) ? ~|{seq_hi, seq_lo} : ~|res;
  end

  // Control FSM: capture on accept, iterate in RUN, publish results in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cin_d   = cin_q;
    out_d   = out_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    busy_d  = (state_q == ST_RUN);
    case (state_q)
      ST_RUN:  if (seq_last) state_d = ST_DONE;
      ST_DONE: begin
        out_d   = res;
        hi_d    = res_hi;
        flags_d = {v, res[WIDTH-1], c, z};
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      a_d     = bus.rD_data;
      b_d     = b_sel;
      op_d    = bus.op;
      cin_d   = bus.flags_in[FLAG_C];
      state_d = is_long ? ST_RUN : ST_DONE;
    end
  end

  // All state and outputs registered; reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_hi    = hi_q;
  assign bus.flags_out = flags_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
